// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: AHB-Lite bus codes and the SRAM slave FSM encoding shared by master and slave
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slave_state_e;

endpackage

// File: rtl/ahb_sram_mem.sv
// ahb_sram_mem: word SRAM with per-byte write enables, synchronous write and combinational read
module ahb_sram_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Update only the enabled byte lanes; contents are never cleared
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave terminating transfers in a byte-writable word SRAM
module ahb_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int  MEM_DEPTH   = 256,
    parameter int  WAIT_STATES = 0,
    localparam int AW          = $clog2(MEM_DEPTH)
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    slave_state_e  state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d, lanes, lanes_q, mem_we;
    logic [AW-1:0] addr_q;
    logic          write_q, accept, err;
    logic [31:0]   rdata;
    logic          unused_inputs;

    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    // A new address phase is taken only on cycles where this slave is itself ready
    assign accept = HREADYOUT & HSEL & HREADY & HTRANS[1];

    assign err = (HSIZE > HSIZE_WORD)
               | (HSIZE == HSIZE_HALF && HADDR[0])
               | (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00)
               | (HADDR[31:AW+2] != '0);

    assign lanes = HSIZE == HSIZE_BYTE ? 4'b0001 << HADDR[1:0]
                 : HSIZE == HSIZE_HALF ? (HADDR[1] ? 4'b1100 : 4'b0011)
                 : 4'b1111;

    // Next state, wait counter and bus response for the current state
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            ST_IDLE: ;
            ST_DATA: begin
                HREADYOUT = wcnt_q == 4'd0;
                wcnt_d    = wcnt_q == 4'd0 ? wcnt_q : wcnt_q - 4'd1;
                state_d   = wcnt_q == 4'd0 ? ST_IDLE : ST_DATA;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP   = HRESP_ERROR;
                state_d = ST_IDLE;
            end
        endcase
        if (accept) begin
            state_d = err ? ST_ERR1 : ST_DATA;
            wcnt_d  = 4'(WAIT_STATES);
        end
    end

    // State register plus the latched address-phase controls
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= '0;
            lanes_q <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (accept) begin
                write_q <= HWRITE;
                addr_q  <= HADDR[AW+1:2];
                lanes_q <= lanes;
            end
        end
    end

    assign mem_we = (state_q == ST_DATA && wcnt_q == 4'd0 && write_q && !HRESET) ? lanes_q : 4'd0;

    assign HRDATA = (state_q == ST_DATA && !write_q) ? rdata : 32'd0;

    ahb_sram_mem #(.DEPTH(MEM_DEPTH), .AW(AW)) u_mem (
        .clk   (HCLK),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (HWDATA),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed checks of the SRAM slave with 0, 3 and 5 wait states
module tb_ahb_sram_slave;
    import ahb_lite_pkg::*;

    logic        HCLK, HRESET, HWRITE, HMASTLOCK;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        rdy  [3];
    logic        resp [3];
    logic [31:0] rdat [3];
    int          dut, vec, errs;
    logic [31:0] burst_exp [4];

    ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) u0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(dut == 0), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HREADY(rdy[0]), .HWDATA(HWDATA), .HRDATA(rdat[0]), .HREADYOUT(rdy[0]), .HRESP(resp[0]));

    ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(3)) u3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(dut == 1), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HREADY(rdy[1]), .HWDATA(HWDATA), .HRDATA(rdat[1]), .HREADYOUT(rdy[1]), .HRESP(resp[1]));

    ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(5)) u5 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(dut == 2), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HREADY(rdy[2]), .HWDATA(HWDATA), .HRDATA(rdat[2]), .HREADYOUT(rdy[2]), .HRESP(resp[2]));

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ap(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [1:0] t);
        HADDR  = a;
        HWRITE = w;
        HSIZE  = s;
        HTRANS = t;
    endtask

    task automatic idle();
        HTRANS = HTRANS_IDLE;
    endtask

    task automatic wait_rdy(input string tag);
        int n;
        n = 0;
        while (!rdy[dut] && n < 20) begin
            step();
            n++;
        end
        chk(tag, {31'd0, rdy[dut]}, 32'd1);
    endtask

    // Single NONSEQ write that runs to completion and leaves the slave idle
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ap(a, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        HWDATA = d;
        idle();
        wait_rdy("wr_ready");
        step();
    endtask

    initial begin
        vec = 0; errs = 0; dut = 3;
        HRESET = 1'b1; HWDATA = '0; HBURST = HBURST_SINGLE; HPROT = 4'h3; HMASTLOCK = 1'b0;
        ap(32'h0, 1'b0, HSIZE_WORD, HTRANS_IDLE);
        step(); step();
        HRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("reset_hreadyout", {31'd0, rdy[i]}, 32'd1);
            chk("reset_hresp", {31'd0, resp[i]}, 32'd0);
            chk("reset_hrdata", rdat[i], 32'd0);
        end

        // zero wait states: write then pipelined read
        dut = 0;
        ap(32'h10, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        chk("ws0_wr_ready", {31'd0, rdy[0]}, 32'd1);
        HWDATA = 32'hDEAD_BEEF;
        ap(32'h10, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        chk("ws0_rd_ready", {31'd0, rdy[0]}, 32'd1);
        chk("ws0_rd_data", rdat[0], 32'hDEAD_BEEF);
        idle();
        step();
        chk("ws0_idle_rdata", rdat[0], 32'd0);

        // byte and half writes merge into one word
        ap(32'h20, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        HWDATA = 32'h0;
        ap(32'h21, 1'b1, HSIZE_BYTE, HTRANS_NONSEQ);
        step();
        HWDATA = 32'h0000_AB00;
        ap(32'h22, 1'b1, HSIZE_HALF, HTRANS_NONSEQ);
        step();
        HWDATA = 32'h1234_0000;
        ap(32'h20, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        chk("lane_merge", rdat[0], 32'h1234_AB00);
        idle();
        step();

        // back-to-back write then read of the same word
        ap(32'h8, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        HWDATA = 32'h5555_5555;
        ap(32'h8, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        chk("b2b_ready", {31'd0, rdy[0]}, 32'd1);
        chk("b2b_data", rdat[0], 32'h5555_5555);
        idle();
        step();

        // misaligned read, then out-of-range read accepted in ERR2
        ap(32'h402, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        chk("err1_ready", {31'd0, rdy[0]}, 32'd0);
        chk("err1_resp", {31'd0, resp[0]}, 32'd1);
        chk("err1_rdata", rdat[0], 32'd0);
        ap(32'h400, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        chk("err2_ready", {31'd0, rdy[0]}, 32'd1);
        chk("err2_resp", {31'd0, resp[0]}, 32'd1);
        step();
        chk("oor_err1_ready", {31'd0, rdy[0]}, 32'd0);
        chk("oor_err1_resp", {31'd0, resp[0]}, 32'd1);
        idle();
        step();
        chk("oor_err2_ready", {31'd0, rdy[0]}, 32'd1);
        chk("oor_err2_resp", {31'd0, resp[0]}, 32'd1);
        step();
        chk("err_idle_resp", {31'd0, resp[0]}, 32'd0);

        // erroring writes (misaligned word, size 3) must not touch memory
        ap(32'h12, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        chk("mis_wr_resp", {31'd0, resp[0]}, 32'd1);
        HWDATA = 32'h0;
        idle();
        step(); step();
        ap(32'h10, 1'b1, 3'd3, HTRANS_NONSEQ);
        step();
        chk("size3_resp", {31'd0, resp[0]}, 32'd1);
        HWDATA = 32'h0;
        idle();
        step(); step();

        // reset on the completing edge of a write drops it
        ap(32'h10, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        HWDATA = 32'h0;
        HRESET = 1'b1;
        idle();
        step();
        HRESET = 1'b0;
        ap(32'h10, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        chk("mem_unchanged", rdat[0], 32'hDEAD_BEEF);
        idle();
        step();

        // three wait states: INCR4 read burst
        dut = 1;
        burst_exp[0] = 32'hA1A1_0001; burst_exp[1] = 32'hB2B2_0002;
        burst_exp[2] = 32'hC3C3_0003; burst_exp[3] = 32'hD4D4_0004;
        for (int b = 0; b < 4; b++) wr(32'h40 + 32'(4*b), burst_exp[b]);
        HBURST = HBURST_INCR4;
        ap(32'h40, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 3; w++) begin
                chk("ws3_wait_ready", {31'd0, rdy[1]}, 32'd0);
                chk("ws3_wait_resp", {31'd0, resp[1]}, 32'd0);
                step();
            end
            chk("ws3_beat_ready", {31'd0, rdy[1]}, 32'd1);
            chk("ws3_beat_resp", {31'd0, resp[1]}, 32'd0);
            chk("ws3_beat_data", rdat[1], burst_exp[b]);
            if (b < 3) ap(32'h44 + 32'(4*b), 1'b0, HSIZE_WORD, HTRANS_SEQ);
            else idle();
            step();
        end
        HBURST = HBURST_SINGLE;

        // five wait states: reset in the middle of a write
        dut = 2;
        wr(32'h30, 32'h0BAD_F00D);
        ap(32'h30, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        HWDATA = 32'hFFFF_FFFF;
        idle();
        step();
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        chk("midrst_ready", {31'd0, rdy[2]}, 32'd1);
        chk("midrst_resp", {31'd0, resp[2]}, 32'd0);
        chk("midrst_rdata", rdat[2], 32'd0);
        ap(32'h30, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        idle();
        wait_rdy("midrst_rd_ready");
        chk("midrst_old_value", rdat[2], 32'h0BAD_F00D);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
